// File: rtl/mux_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time, steering the granted
// requester's data bit onto a shared output.

module mux_arbiter4_lane #(
  parameter int NUM_REQ = 4,
  parameter int IDX     = 0
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       win
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] d_self;
  logic [IW-1:0] d_j;

  // Distance from the slot after the last winner; the nearest active request wins.
  always_comb begin
    d_self = IW'(IDX) - last - IW'(1);
    d_j    = '0;
    win    = req[IDX];
    for (int j = 0; j < NUM_REQ; j++) begin
      d_j = IW'(j) - last - IW'(1);
      if (j != IDX && req[j] && d_j < d_self) win = 1'b0;
    end
  end
endmodule

module mux_arbiter4 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  output logic [3:0] gnt,
  output logic       sel1,
  output logic       sel2,
  output logic       op,
  output logic       busy
);
  localparam int NUM_REQ = 4;
  localparam int IW      = $clog2(NUM_REQ);
  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IW-1:0]      last;
  logic [2:0]         hold_cnt;
  logic [IW-1:0]      sel_q;
  logic [NUM_REQ-1:0] win;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] din;
  logic               any_req;
  logic               release_now;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    mux_arbiter4_lane #(.NUM_REQ(NUM_REQ), .IDX(k)) u_lane (
      .req  (req),
      .last (last),
      .win  (win[k])
    );
  end

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (win[k]) win_idx = IW'(k);
  end

  assign any_req     = |req;
  // last always names the current owner while in GRANT.
  assign release_now = !req[last] || (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel_q    <= '0;
      hold_cnt <= '0;
      last     <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= GRANT;
            gnt      <= win;
            sel_q    <= win_idx;
            last     <= win_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            hold_cnt <= '0;
            if (any_req) begin
              gnt   <= win;
              sel_q <= win_idx;
              last  <= win_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              sel_q <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel1 = sel_q[1];
  assign sel2 = sel_q[0];
  assign busy = |gnt;
  assign din  = {i4, i3, i2, i1};
  assign op   = busy & din[sel_q];
endmodule

// File: tb/tb_mux_arbiter4.sv
// Directed bench for mux_arbiter4 (MAX_HOLD = 4) with a per-cycle invariant checker.

module tb_mux_arbiter4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       i1, i2, i3, i4;
  logic [3:0] gnt;
  logic       sel1, sel2, op, busy;

  int n_vec = 0;
  int n_bad = 0;

  mux_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .gnt(gnt), .sel1(sel1), .sel2(sel2), .op(op), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic [3:0] v);
    {i4, i3, i2, i1} = v;
  endtask

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    logic [1:0] s;
    logic [3:0] dv;
    s  = {sel1, sel2};
    dv = {i4, i3, i2, i1};
    chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("inv_busy", 32'(busy), 32'(|gnt));
    chk("inv_sel_gnt", 32'(gnt), busy ? 32'(4'b0001 << s) : 32'd0);
    chk("inv_op", 32'(op), busy ? 32'(dv[s]) : 32'd0);
  end

  initial begin
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    logic [3:0] ipat;

    rst_n = 1'b0; req = 4'b0000; set_i(4'b0000);
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'({sel1, sel2}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    rst_n = 1'b1;

    // Single requester, one-cycle latency, zero data latency, release to idle.
    req = 4'b0001; set_i(4'b0001);
    step();
    chk("r1_gnt", 32'(gnt), 32'h1);
    chk("r1_sel", 32'({sel1, sel2}), 32'd0);
    chk("r1_op", 32'(op), 32'd1);
    chk("r1_busy", 32'(busy), 32'd1);
    set_i(4'b0000); #1;
    chk("r1_op_comb", 32'(op), 32'd0);
    set_i(4'b0001);
    req = 4'b0000;
    step();
    chk("r1_rel_gnt", 32'(gnt), 32'd0);
    chk("r1_rel_op", 32'(op), 32'd0);

    // All requesting: 4-cycle round-robin slots, no bubbles.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    ipat = 4'b1010; set_i(ipat);
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      exp_s = 2'((c / 4) % 4);
      exp_g = 4'b0001 << exp_s;
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_sel", 32'({sel1, sel2}), 32'(exp_s));
      chk("rr_op", 32'(op), 32'(ipat[exp_s]));
    end
    req = 4'b0000;
    step();
    chk("rr_idle", 32'(gnt), 32'd0);

    // Lone requester re-granted across each hold expiry.
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("solo_gnt", 32'(gnt), 32'h4);
      chk("solo_hold", 32'(dut.hold_cnt), 32'(c % 4));
    end
    req = 4'b0000;
    step();
    chk("solo_idle", 32'(gnt), 32'd0);

    // Owner 0010, late request from 4 must not preempt, hand-off on owner drop.
    req = 4'b0010;
    step();
    chk("pre_gnt0", 32'(gnt), 32'h2);
    step();
    chk("pre_hold1", 32'(dut.hold_cnt), 32'd1);
    req = 4'b1010;
    step();
    chk("pre_nopre", 32'(gnt), 32'h2);
    chk("pre_hold2", 32'(dut.hold_cnt), 32'd2);
    req = 4'b1000;
    step();
    chk("pre_hand_gnt", 32'(gnt), 32'h8);
    chk("pre_hand_sel", 32'({sel1, sel2}), 32'd3);
    chk("pre_hand_hold", 32'(dut.hold_cnt), 32'd0);

    // Reset mid-grant aborts; requester 1 then has first priority.
    set_i(4'b1111);
    rst_n = 1'b0;
    step();
    chk("mrst_gnt", 32'(gnt), 32'd0);
    chk("mrst_sel", 32'({sel1, sel2}), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_op", 32'(op), 32'd0);
    rst_n = 1'b1;
    req = 4'b1001;
    step();
    chk("mrst_win", 32'(gnt), 32'h1);
    chk("mrst_hold", 32'(dut.hold_cnt), 32'd0);
    req = 4'b0000;
    step();
    // Owner dropped while requester 4 also dropped: back to idle.
    chk("end_idle", 32'(gnt), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
